// File: rtl/mux_scan_ctrl.sv
// Clocked scanner for an external 8:1 mux: steps the select through channels 0..7,
// samples a1 after DWELL settle cycles per channel and offers the snapshot over valid/ready.
module mux_scan_ctrl #(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       a1,
    input  logic       ready,
    output logic       s1,
    output logic       s2,
    output logic       s3,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy
);

    localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    state_t        state, state_d;
    logic [2:0]    chan, chan_d;
    logic [2:0]    sel, sel_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0]    shadow, shadow_d;
    logic [7:0]    data_d;
    logic          valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            chan   <= 3'd0;
            sel    <= 3'd0;
            cnt    <= '0;
            shadow <= 8'd0;
            data   <= 8'd0;
            valid  <= 1'b0;
        end else begin
            state  <= state_d;
            chan   <= chan_d;
            sel    <= sel_d;
            cnt    <= cnt_d;
            shadow <= shadow_d;
            data   <= data_d;
            valid  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state;
        chan_d   = chan;
        cnt_d    = cnt;
        shadow_d = shadow;
        data_d   = data;
        valid_d  = valid;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    chan_d   = 3'd0;
                    cnt_d    = CNT_LOAD;
                    shadow_d = 8'd0;
                end
            end

            SETTLE: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    shadow_d[chan] = a1;
                    if (chan != 3'd7) begin
                        chan_d = chan + 3'd1;
                        cnt_d  = CNT_LOAD;
                    end else begin
                        // Last channel goes straight into data so the snapshot is presented this edge.
                        data_d  = shadow_d;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
            end

            HOLD: begin
                if (ready) begin
                    valid_d = 1'b0;
                    if (start) begin
                        state_d  = SETTLE;
                        chan_d   = 3'd0;
                        cnt_d    = CNT_LOAD;
                        shadow_d = 8'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Select register follows the channel that will be active after this edge.
        sel_d = (state_d == SETTLE) ? chan_d : 3'd0;
    end

    assign {s1, s2, s3} = sel;
    assign busy         = (state == SETTLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: table-driven scans and corner sequences on a DWELL=2 instance,
// back-to-back throughput on a DWELL=1 instance, random traffic against a cycle-count model.
module tb_mux_scan_ctrl;

    localparam int D0 = 2;
    localparam int D1 = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start0, ready0, a1_0, valid0, busy0;
    logic [7:0] in0, data0;
    logic [2:0] sel0;
    logic       start1, ready1, a1_1, valid1, busy1;
    logic [7:0] in1, data1;
    logic [2:0] sel1;

    assign a1_0 = in0[sel0];
    assign a1_1 = in1[sel1];

    mux_scan_ctrl #(.DWELL(D0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a1(a1_0), .ready(ready0),
        .s1(sel0[2]), .s2(sel0[1]), .s3(sel0[0]),
        .data(data0), .valid(valid0), .busy(busy0)
    );

    mux_scan_ctrl #(.DWELL(D1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a1(a1_1), .ready(ready1),
        .s1(sel1[2]), .s2(sel1[1]), .s3(sel1[0]),
        .data(data1), .valid(valid1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    typedef struct {
        logic [7:0] pat;
        logic [7:0] exp_data;
        int         exp_lat;
    } vec_t;
    vec_t tbl [6];

    int          n, g, last, nsel;
    logic [23:0] seq;
    logic        exp_bit;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] pat, input logic st, input logic rdy);
        @(negedge clk);
        in0    = pat;
        start0 = st;
        ready0 = rdy;
    endtask

    task automatic waitValid0(input int limit, output int cycles);
        cycles = 0;
        while (!valid0 && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic scanOnce0(input string name, input logic [7:0] pat, input logic [7:0] exp_data,
                             input int exp_lat);
        int lat;
        applyStimulus(pat, 1'b1, 1'b1);
        applyStimulus(pat, 1'b0, 1'b1);
        waitValid0(40, lat);
        checkOutput({name, "_latency"}, lat, exp_lat);
        checkOutput({name, "_data"}, 32'(data0), 32'(exp_data));
        @(negedge clk);
        checkOutput({name, "_idle"}, 32'({valid0, busy0, sel0}), 32'd0);
    endtask

    // Reference model: tracks phase and elapsed cycles since the accepted start; channel k
    // is captured once k+1 whole dwells have elapsed, using the input as it stood then.
    typedef enum int {M_IDLE, M_SCAN, M_HOLD} mphase_t;
    mphase_t    m_phase;
    int         m_cyc, m_t0, m_e, m_k;
    logic [7:0] m_snap, m_data;
    logic       m_valid;
    logic [2:0] m_sel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = M_IDLE;
            m_snap  = 8'd0;
            m_data  = 8'd0;
            m_valid = 1'b0;
            m_sel   = 3'd0;
            m_t0    = 0;
        end else begin
            m_cyc++;
            case (m_phase)
                M_IDLE: if (start0) begin
                    m_phase = M_SCAN;
                    m_t0    = m_cyc;
                    m_snap  = 8'd0;
                end
                M_SCAN: begin
                    m_e = m_cyc - m_t0;
                    if (m_e % D0 == 0) begin
                        m_k = m_e / D0 - 1;
                        m_snap[m_k[2:0]] = in0[m_k[2:0]];
                        if (m_k == 7) begin
                            m_data  = m_snap;
                            m_valid = 1'b1;
                            m_phase = M_HOLD;
                        end
                    end
                end
                M_HOLD: if (ready0) begin
                    m_valid = 1'b0;
                    if (start0) begin
                        m_phase = M_SCAN;
                        m_t0    = m_cyc;
                        m_snap  = 8'd0;
                    end else begin
                        m_phase = M_IDLE;
                    end
                end
                default: m_phase = M_IDLE;
            endcase
            m_sel = (m_phase == M_SCAN) ? 3'((m_cyc - m_t0) / D0) : 3'd0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && model_on)
            checkOutput("model", 32'({data0, valid0, sel0, busy0}),
                        32'({m_data, m_valid, m_sel, (m_phase == M_SCAN)}));
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0; ready0 = 1'b0; in0 = 8'd0;
        start1 = 1'b0; ready1 = 1'b0; in1 = 8'd0;
        m_cyc  = 0;

        tbl[0] = '{pat: 8'hA5, exp_data: 8'hA5, exp_lat: 16};
        tbl[1] = '{pat: 8'h00, exp_data: 8'h00, exp_lat: 16};
        tbl[2] = '{pat: 8'hFF, exp_data: 8'hFF, exp_lat: 16};
        tbl[3] = '{pat: 8'h3C, exp_data: 8'h3C, exp_lat: 16};
        tbl[4] = '{pat: 8'h81, exp_data: 8'h81, exp_lat: 16};
        tbl[5] = '{pat: 8'h5A, exp_data: 8'h5A, exp_lat: 16};

        repeat (2) @(negedge clk);
        checkOutput("reset0", 32'({data0, valid0, busy0, sel0}), 32'd0);
        checkOutput("reset1", 32'({data1, valid1, busy1, sel1}), 32'd0);
        #2 rst_n = 1'b1;
        model_on = 1'b1;

        $display("[TB] table-driven scans");
        for (int i = 0; i < 6; i++)
            scanOnce0($sformatf("vec%0d", i), tbl[i].pat, tbl[i].exp_data, tbl[i].exp_lat);

        $display("[TB] backpressure");
        applyStimulus(8'hA5, 1'b1, 1'b0);
        applyStimulus(8'hA5, 1'b0, 1'b0);
        waitValid0(40, n);
        checkOutput("bp_latency", n, 16);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("bp_hold", 32'({valid0, data0, sel0, busy0}), 32'({1'b1, 8'hA5, 3'd0, 1'b0}));
        end
        applyStimulus(8'hA5, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("bp_release", 32'({valid0, data0}), 32'({1'b0, 8'hA5}));

        $display("[TB] reset mid-scan");
        applyStimulus(8'h5A, 1'b1, 1'b1);
        applyStimulus(8'h5A, 1'b0, 1'b1);
        n = 0;
        while (sel0 != 3'd4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("mid_sel4", 32'(sel0), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_reset", 32'({data0, valid0, busy0, sel0}), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        scanOnce0("post_reset", 8'hFF, 8'hFF, 16);

        $display("[TB] start held during scan");
        applyStimulus(8'h96, 1'b1, 1'b0);
        @(negedge clk);
        n = 0; seq = 24'd0; nsel = 0; last = -1;
        while (!valid0 && n < 40) begin
            if (busy0 && int'(sel0) != last) begin
                seq  = {seq[20:0], sel0};
                nsel++;
                last = int'(sel0);
            end
            @(negedge clk);
            n++;
        end
        checkOutput("held_latency", n, 16);
        checkOutput("held_nsel", nsel, 8);
        checkOutput("held_seq", 32'(seq), 32'(24'o01234567));
        checkOutput("held_data", 32'(data0), 32'h96);
        applyStimulus(8'h96, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("held_idle", 32'({valid0, busy0}), 32'd0);

        $display("[TB] input glitch outside channel 2");
        for (int r = 0; r < 4; r++) begin
            applyStimulus(8'h00, 1'b1, 1'b1);
            applyStimulus(8'h00, 1'b0, 1'b1);
            n = 0;
            exp_bit = 1'b0;
            while (!valid0 && n < 40) begin
                if (sel0 == 3'd2) exp_bit = in0[2];
                else              in0[2]  = 1'($urandom);
                @(negedge clk);
                n++;
            end
            checkOutput("glitch", 32'(data0), 32'({5'd0, exp_bit, 2'd0}));
            @(negedge clk);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start0 = ($urandom_range(0, 3) == 0);
            ready0 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) in0 = 8'($urandom);
        end
        applyStimulus(in0, 1'b0, 1'b1);
        n = 0;
        while ((valid0 || busy0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 32'({valid0, busy0}), 32'd0);

        $display("[TB] DWELL=1 back-to-back");
        @(negedge clk);
        in1 = 8'h3C; start1 = 1'b1; ready1 = 1'b1;
        @(negedge clk);
        n = 0;
        while (!valid1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_latency", n, 8);
        checkOutput("b2b_first", 32'(data1), 32'h3C);
        in1 = 8'hC3;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!valid1 && g < 30);
        checkOutput("b2b_gap", g, 9);
        checkOutput("b2b_second", 32'(data1), 32'hC3);
        start1 = 1'b0;
        @(negedge clk);
        checkOutput("b2b_idle", 32'({valid1, busy1}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer that sits directly upstream of the 8:1 select mux. It drives the mux select lines `s1`, `s2`, `s3` through all eight channels, samples the mux output `a1` after a programmable settle time, and assembles one 8-bit snapshot of inputs `i1`..`i8`. The snapshot goes to a downstream consumer over a valid/ready handshake, which turns the combinational mux into a clocked 8-channel scanner.

## Interface
- `DWELL`, default 2: cycles each channel is selected before `a1` is sampled; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one scan; sampled only in IDLE, or in HOLD together with a handshake.
- `s1`  out  1  select MSB; registered.
- `s2`  out  1  select middle bit; registered.
- `s3`  out  1  select LSB; registered.
- `a1`  in  1  mux output for the current select.
- `data`  out  8  snapshot; bit k = `a1` sampled with select = k (bit 0 = `i1`, bit 7 = `i8`).
- `valid`  out  1  `data` holds a complete snapshot.
- `ready`  in  1  consumer accepts `data` when `valid` and `ready` are both 1 at a rising edge.
- `busy`  out  1  scan in progress (SETTLE state).

## Operation
- Registers:
  - state: IDLE, SETTLE, HOLD.
  - `chan` (3 bits): current channel.
  - `cnt`: dwell counter, width = ceil(log2(DWELL)), minimum 1.
  - `shadow` (8 bits): capture register.
  - `data` (8 bits) and `valid`.
- `{s1,s2,s3}` = `chan` while in SETTLE, 3'b000 in IDLE and HOLD.
- IDLE:
  - `start` = 1 → SETTLE, `chan` = 0, `cnt` = DWELL-1, `shadow` = 0.
  - Otherwise stay.
- SETTLE:
  - `cnt` != 0: decrement.
  - `cnt` == 0: `shadow[chan]` <= `a1`.
  - `chan` < 7: `chan` += 1, `cnt` = DWELL-1.
  - `chan` == 7: `data` <= `shadow` with bit 7 replaced by `a1`, `valid` <= 1, go to HOLD.
  - `chan` advances 0→7 only; no wrap inside one scan.
- HOLD:
  - `valid` = 1; `data` stable.
  - On `valid` && `ready`: `valid` <= 0.
    - `start` = 1 at the same edge → SETTLE with `chan` = 0 (back-to-back scan).
    - Otherwise → IDLE.
  - `ready` = 0: stay indefinitely.
- `start` in SETTLE, or in HOLD without a handshake, is ignored. It is not queued.
- `ready` while `valid` = 0 is ignored.
- `busy` = 1 exactly in SETTLE.
- Reset, at any time including mid-scan:
  - state IDLE; `chan`, `cnt`, `shadow`, `data` = 0.
  - `valid`, `busy`, `s1`, `s2`, `s3` = 0.
  - A partial snapshot is discarded and never presented.

## Timing
- `start` accepted at edge T. Select k is driven from edge T+k·DWELL.
- `a1` for channel k is sampled at edge T+(k+1)·DWELL, after DWELL full cycles of settle.
- `valid` rises at edge T+8·DWELL. Scan latency = 8·DWELL cycles.
- DWELL = 1: select changes every cycle; `a1` is sampled one cycle after each select update.
- Back-to-back throughput: one snapshot per 8·DWELL+1 cycles (one HOLD cycle when `ready` is held at 1).
- The mux is combinational. `a1` must settle within one cycle of a select change; DWELL beyond 1 is margin for external drivers.
- `data` changes only at the edge that sets `valid`.

## Test plan
- DWELL = 2; `i1`..`i8` = 1,0,1,0,0,1,0,1 (pattern 8'hA5); pulse `start` at edge 0; `ready` held 1 → select steps 0..7 every 2 cycles; `valid` = 1 after edge 16; `data` = 8'hA5; IDLE after edge 17.
- Backpressure: same inputs, `ready` = 0 for 20 cycles after `valid` → `valid` and `data` = 8'hA5 held, selects = 0; raise `ready` → `valid` falls the next edge.
- Reset mid-scan: assert `rst_n` = 0 while select = 4 → all outputs 0 immediately; release, then start a new scan with all inputs = 1 → `data` = 8'hFF, with no residue from the aborted scan.
- `start` held high during SETTLE → no restart; `chan` sequence is 0..7 exactly once; `valid` at T+8·DWELL.
- DWELL = 1, `start` and `ready` held 1; inputs change 8'h3C → 8'hC3 between scans → consecutive snapshots 8'h3C, 8'hC3, each 9 cycles apart.
- Input glitch: change `i3` only while select != 2 → the captured bit 2 reflects `i3` as it stood during channel 2's dwell.
